// File: rtl/acc_sched_if.sv
// rtl/acc_sched_if.sv - requester/result bundle between operand producers and acc_sched
interface acc_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   opnd_vld;
  logic [NREQ*W-1:0] opnd;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [W-1:0]      result;
  logic              result_cout;
  logic [IDW-1:0]    result_id;
  logic              done;

  modport master (
    output req, opnd_vld, opnd, last,
    input  gnt, busy, result, result_cout, result_id, done
  );

  modport slave (
    input  req, opnd_vld, opnd, last,
    output gnt, busy, result, result_cout, result_id, done
  );
endinterface

// File: rtl/acc_sched.sv
// rtl/acc_sched.sv - round-robin scheduler sharing one accumulator among NREQ requesters
// ACC_SCHED_SAT_EN: clamp the accumulator to all-ones on carry-out instead of wrapping.
module acc_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic        clk,
  input  logic        clear_n,
  acc_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_q;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  cand;
  logic            win_found;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic            cy;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic [IDW-1:0]  id_q;
  logic            req_k, vld_k, last_k;
  logic [W-1:0]    opnd_k;
  logic [W:0]      sum;
  logic            carry;
  logic            accept;

  // ptr holds the last winner, which is also the currently granted requester in RUN
  always_comb begin
    req_k  = 1'b0;
    vld_k  = 1'b0;
    last_k = 1'b0;
    opnd_k = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr == IDW'(i)) begin
        req_k  = bus.req[i];
        vld_k  = bus.opnd_vld[i];
        last_k = bus.last[i];
        opnd_k = bus.opnd[i*W +: W];
      end
    end
  end

  // Search from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = (state == RUN) & req_k & vld_k;
  assign sum    = {1'b0, acc} + {1'b0, opnd_k};
  assign carry  = sum[W];

`ifdef ACC_SCHED_SAT_EN
  assign acc_nxt = carry ? {W{1'b1}} : sum[W-1:0];
`else
  assign acc_nxt = sum[W-1:0];
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = RUN;
      RUN: begin
        if (!req_k)                state_nxt = IDLE;
        else if (accept && last_k) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      gnt_q    <= '0;
      ptr      <= IDW'(NREQ - 1);
      acc      <= '0;
      cy       <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            ptr   <= win_idx;
            gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            acc   <= '0;
            cy    <= 1'b0;
          end
        end
        RUN: begin
          if (!req_k) begin
            gnt_q <= '0;
          end else if (accept) begin
            acc <= acc_nxt;
            cy  <= cy | carry;
            if (last_k) begin
              result_q <= acc_nxt;
              cout_q   <= cy | carry;
              id_q     <= ptr;
              gnt_q    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state == RUN) || (state == DONE);
    bus.done        = (state == DONE);
    bus.gnt         = gnt_q;
    bus.result      = result_q;
    bus.result_cout = cout_q;
    bus.result_id   = id_q;
  end

endmodule

// File: tb/tb_acc_sched.sv
// tb/tb_acc_sched.sv - randomized self-checking bench for acc_sched against a burst-level model
module tb_acc_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic clear_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_last;
  logic [7:0] m_result;

  always #5 clk = ~clk;

  acc_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  acc_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  function automatic int rr_pick(input logic [3:0] mask, input int lastw);
    for (int off = 1; off <= 4; off++)
      if (mask[(lastw + off) % 4]) return (lastw + off) % 4;
    return -1;
  endfunction

  // Sum of a burst as plain integer arithmetic; carry-out iff the total ever exceeded 2^W-1.
  function automatic logic [8:0] burst_model(input logic [7:0] ops [8], input int n);
    int total;
    logic c;
    logic [7:0] r;
    total = 0;
    for (int j = 0; j < n; j++) total += int'(ops[j]);
    c = (total > 255);
`ifdef ACC_SCHED_SAT_EN
    r = c ? 8'd255 : 8'(total);
`else
    r = 8'(total % 256);
`endif
    return {c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req = '0; bus.opnd_vld = '0; bus.last = '0; bus.opnd = '0;
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    m_last = 3;
    m_result = 8'd0;
  endtask

  task automatic do_burst(input logic [3:0] mask, input int k, input int n, input logic [7:0] ops [8],
                          input bit gap, output int lat, output logic [3:0] g, output int ddly,
                          output logic [7:0] r, output logic rc, output logic [1:0] rid);
    logic [3:0] oh;
    oh = 4'(1 << k);
    lat = -1; g = '0; ddly = -1; r = '0; rc = 1'b0; rid = '0;
    bus.req = mask;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.gnt !== 4'b0000) begin lat = c; g = bus.gnt; break; end
    end
    if (lat < 0) begin
      bus.req = '0;
      return;
    end
    bus.req = oh;
    for (int j = 0; j < n; j++) begin
      if (gap && j > 0) begin
        bus.opnd_vld = 4'($urandom) & ~oh;
        bus.last = 4'($urandom) & ~oh;
        tick();
      end
      bus.opnd = $urandom;
      bus.opnd[k*8 +: 8] = ops[j];
      bus.opnd_vld = (4'($urandom) & ~oh) | oh;
      bus.last = (4'($urandom) & ~oh) | ((j == n - 1) ? oh : 4'b0000);
      tick();
    end
    bus.req = '0; bus.opnd_vld = '0; bus.last = '0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done === 1'b1) begin
        ddly = c; r = bus.result; rc = bus.result_cout; rid = bus.result_id;
        break;
      end
      tick();
    end
    if (ddly >= 0) tick();
  endtask

  task automatic test_reset();
    bus.req = 4'hf; bus.opnd_vld = 4'hf; bus.last = 4'hf; bus.opnd = $urandom;
    clear_n = 1'b0;
    #7;
    n_tests++; if (bus.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 8'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", bus.result); end
    n_tests++; if (bus.result_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", bus.result_cout); end
    n_tests++; if (bus.result_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.result_id); end
    apply_reset();
    repeat (2) tick();
    n_tests++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle got gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy); end
  endtask

  task automatic test_round_robin();
    int ev_cyc [$];
    logic [3:0] ev_g [$];
    int lastw, exp_w, nd;
    logic [3:0] exp_g;
    apply_reset();
    bus.opnd = {4{8'd1}}; bus.opnd_vld = 4'hf; bus.last = 4'hf; bus.req = 4'hf;
    lastw = m_last; nd = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.gnt !== 4'b0) begin ev_cyc.push_back(c); ev_g.push_back(bus.gnt); end
      if (bus.done === 1'b1) begin
        n_tests++;
        if (bus.result !== 8'd1 || bus.result_id !== 2'(nd % 4)) begin
          n_fail++; $display("FAIL rr_done%0d got result=%0d id=%0d want 1/%0d", nd, bus.result, bus.result_id, nd % 4);
        end
        nd++;
      end
    end
    n_tests++;
    if (ev_g.size() < 5) begin
      n_fail++; $display("FAIL rr_grant_count got %0d want >=5", ev_g.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_w = rr_pick(4'hf, lastw); lastw = exp_w; exp_g = 4'(1 << exp_w);
        n_tests++; if (ev_g[i] !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", i, ev_g[i], exp_g); end
      end
      n_tests++; if (ev_cyc[0] !== 1) begin n_fail++; $display("FAIL rr_latency got %0d want 1", ev_cyc[0]); end
      for (int i = 1; i < 5; i++) begin
        n_tests++; if (ev_cyc[i] - ev_cyc[i-1] !== 3) begin n_fail++; $display("FAIL rr_gap%0d got %0d want 3", i, ev_cyc[i] - ev_cyc[i-1]); end
      end
    end
    apply_reset();
  endtask

  task automatic run_and_check(input string nm, input logic [3:0] mask, input int n,
                               input logic [7:0] ops [8], input bit gap);
    int k, lat, ddly;
    logic [3:0] g;
    logic [7:0] r;
    logic rc;
    logic [1:0] rid;
    logic [8:0] m;
    k = rr_pick(mask, m_last);
    m = burst_model(ops, n);
    do_burst(mask, k, n, ops, gap, lat, g, ddly, r, rc, rid);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL %s_latency got %0d want 1", nm, lat); end
    n_tests++; if (g !== 4'(1 << k)) begin n_fail++; $display("FAIL %s_gnt got %b want %b", nm, g, 4'(1 << k)); end
    n_tests++; if (ddly !== 0) begin n_fail++; $display("FAIL %s_done_delay got %0d want 0", nm, ddly); end
    n_tests++; if (r !== m[7:0]) begin n_fail++; $display("FAIL %s_result got %0d want %0d", nm, r, m[7:0]); end
    n_tests++; if (rc !== m[8]) begin n_fail++; $display("FAIL %s_cout got %b want %b", nm, rc, m[8]); end
    n_tests++; if (rid !== 2'(k)) begin n_fail++; $display("FAIL %s_id got %0d want %0d", nm, rid, k); end
    m_last = k;
    m_result = m[7:0];
  endtask

  task automatic test_basic();
    logic [7:0] ops [8];
    ops = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_and_check("basic", 4'b0001, 3, ops, 1'b0);
  endtask

  task automatic test_abort();
    logic [7:0] ops [8];
    int seen_done;
    bus.req = 4'b0010;
    tick();
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt got %b want 0010", bus.gnt); end
    bus.opnd = '0; bus.opnd[8 +: 8] = 8'd5; bus.opnd_vld = 4'b0010;
    tick();
    bus.opnd_vld = '0; bus.req = '0;
    tick();
    n_tests++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_release got gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy); end
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen_done); end
    n_tests++; if (bus.result !== m_result) begin n_fail++; $display("FAIL abort_result_held got %0d want %0d", bus.result, m_result); end
    m_last = 1;
    ops = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    n_tests++; if (rr_pick(4'b1101, m_last) !== 2) begin n_fail++; $display("FAIL abort_model_pick got %0d want 2", rr_pick(4'b1101, m_last)); end
    run_and_check("after_abort", 4'b1101, 1, ops, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] ops [8];
    ops = '{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_and_check("wrap", 4'b0100, 2, ops, 1'b0);
  endtask

  task automatic test_gapped();
    logic [7:0] ops [8];
    ops = '{8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_and_check("gapped", 4'b0010, 2, ops, 1'b1);
  endtask

  task automatic test_clear_mid();
    logic [7:0] ops [8];
    bus.req = 4'b1000;
    tick();
    n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL clr_gnt got %b want 1000", bus.gnt); end
    bus.opnd = '0; bus.opnd[24 +: 8] = 8'd50; bus.opnd_vld = 4'b1000; bus.last = '0;
    tick();
    bus.opnd[24 +: 8] = 8'd60;
    tick();
    #3;
    clear_n = 1'b0;
    #1;
    n_tests++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'd0 ||
        bus.result_cout !== 1'b0 || bus.result_id !== 2'd0) begin
      n_fail++;
      $display("FAIL clr_async got gnt=%b busy=%b done=%b result=%0d cout=%b id=%0d want all 0",
               bus.gnt, bus.busy, bus.done, bus.result, bus.result_cout, bus.result_id);
    end
    bus.req = '0; bus.opnd_vld = '0;
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    m_last = 3;
    m_result = 8'd0;
    ops = '{8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_and_check("clr_restart", 4'b1000, 2, ops, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] ops [8];
    logic [3:0] mask;
    int n;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 6);
      for (int j = 0; j < 8; j++) ops[j] = 8'($urandom);
      if (it % 5 == 0) for (int j = 0; j < 8; j++) ops[j] = 8'($urandom_range(0, 40));
      run_and_check($sformatf("rand%0d", it), mask, n, ops, ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    clear_n = 1'b0;
    bus.req = '0; bus.opnd_vld = '0; bus.last = '0; bus.opnd = '0;
    test_reset();
    test_round_robin();
    test_basic();
    test_abort();
    test_wrap();
    test_gapped();
    test_clear_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
